multi_ctrl: RTL and testbench
=============================

# multi_ctrl

Main control finite-state machine for the multi-cycle MIPS processor. It sequences the shared datapath through fetch, decode, execute, memory and write-back steps for each instruction. It drives the datapath's mux selects and write enables, and drives the 2-bit `ALUop` consumed by the ALU-control decoder. It also stalls on a memory-ready handshake so the same datapath works with multi-cycle memory.

## Interface
Parameters: none.
- `clk`  in  1  single clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `Op`  in  6  opcode field from instruction register (IR[31:26])
- `Zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory completes current read/write this cycle
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `MemtoReg`, `IRWrite`, `ALUSrcA`, `RegWrite`, `RegDst`  out  1 each  datapath controls
- `PCSource`  out  2  00 ALU result, 01 ALUOut, 10 jump target
- `ALUSrcB`  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2
- `ALUop`  out  2  00 add, 01 sub (beq), 10 R-type funct decode
- `PCen`  out  1  `PCWrite | (PCWriteCond & Zero)`
- `illegal_op`  out  1  one-cycle flag for an unsupported opcode
- `state`  out  4  current state encoding, for debug

## Operation
- States and encodings:
  - FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5
  - EXEC 6, RWB 7, BEQ 8, JUMP 9, ADDIEX 10, ADDIWB 11
- Outputs are a Moore decode of `state`, except the `mem_ready`-gated and `illegal_op` terms. Any control not listed for a state is 0.
- FETCH: `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUop`=00, `PCSource`=00.
  - `IRWrite` = `PCWrite` = `mem_ready`.
  - Stays in FETCH until `mem_ready`, then goes to DECODE.
- DECODE: `ALUSrcA`=0, `ALUSrcB`=11, `ALUop`=00. Next state by `Op`:
  - 000000 → EXEC
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000100 → BEQ
  - 000010 → JUMP
  - 001000 → ADDIEX
  - any other opcode → FETCH with `illegal_op`=1 during DECODE
- MEMADR: `ALUSrcA`=1, `ALUSrcB`=10, `ALUop`=00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: `MemRead`=1, `IorD`=1. Holds until `mem_ready`, then goes to MEMWB.
- MEMWB: `RegDst`=0, `MemtoReg`=1, `RegWrite`=1. Then FETCH.
- MEMWR: `MemWrite`=1, `IorD`=1. Holds until `mem_ready`, then goes to FETCH.
- EXEC: `ALUSrcA`=1, `ALUSrcB`=00, `ALUop`=10. Then RWB.
- RWB: `RegDst`=1, `MemtoReg`=0, `RegWrite`=1. Then FETCH.
- BEQ: `ALUSrcA`=1, `ALUSrcB`=00, `ALUop`=01, `PCWriteCond`=1, `PCSource`=01. Then FETCH.
- JUMP: `PCWrite`=1, `PCSource`=10. Then FETCH.
- ADDIEX: `ALUSrcA`=1, `ALUSrcB`=10, `ALUop`=00. Then ADDIWB.
- ADDIWB: `RegDst`=0, `MemtoReg`=0, `RegWrite`=1. Then FETCH.
- `Op` is sampled only in DECODE and MEMADR. It is stable there because `IRWrite` is low.
- Unreachable encodings 12–15 go to FETCH on the next edge.

## Timing
- Reset:
  - `rst`=1 at a rising edge puts `state` in FETCH, from any state including mid-instruction or during a memory wait.
  - While `rst`=1, every output except `state` is forced to 0. This includes `MemRead`, `PCWrite`, `IRWrite`, `PCen` and `illegal_op`.
- Latency with `mem_ready` held high (cycles from FETCH entry back to FETCH):
  - R-type 4, lw 5, sw 4, beq 3, j 3, addi 4.
- Each cycle `mem_ready` is low in FETCH, MEMRD or MEMWR adds exactly one cycle. All outputs hold steady during the wait.
- `mem_ready` is ignored in every other state.
- `PCen` is combinational in the same cycle. In BEQ it is asserted only if `Zero`=1.

## Configuration
- `MULTI_CTRL_ADDI_EN` defined: ADDIEX and ADDIWB exist, and `Op`=001000 is decoded as addi.
- Not defined: both states are removed. `Op`=001000 is treated as illegal: DECODE goes to FETCH with `illegal_op`=1.

## Test plan
- Reset: `rst`=1 for 2 cycles in the middle of a MEMRD wait.
  - Response: `state`=0 and all controls 0 during reset. After `rst` falls, the first cycle shows `MemRead`=1, `ALUSrcB`=01.
- R-type with `mem_ready`=1 and `Op`=000000.
  - Response: states 0,1,6,7,0. `ALUop`=10 in EXEC; `RegWrite`=1, `RegDst`=1 in RWB.
- lw with memory waits: `Op`=100011, `mem_ready` low for 2 cycles in FETCH and 3 cycles in MEMRD.
  - Response: 10 cycles total. `IRWrite` pulses once. `MemtoReg`=1 and `RegWrite`=1 in MEMWB.
- beq: run once with `Zero`=1 and once with `Zero`=0.
  - Response: `ALUop`=01 and `PCSource`=01 in BEQ. `PCen`=1 and 0 respectively.
- jump then illegal opcode: `Op`=000010, then `Op`=111111.
  - Response: JUMP has `PCWrite`=1, `PCSource`=10. The illegal opcode returns to FETCH after DECODE with `illegal_op`=1 for one cycle.
- addi: `Op`=001000.
  - With `MULTI_CTRL_ADDI_EN`: states 0,1,10,11,0, with `ALUSrcB`=10 then `RegWrite`=1.
  - Without it: `illegal_op`=1 in DECODE.

Source files
------------

// File: rtl/multi_ctrl.sv
// rtl/multi_ctrl.sv - main control FSM for the multi-cycle MIPS datapath
//
// Purpose: sequences fetch/decode/execute/memory/write-back steps for each
// instruction, drives datapath mux selects and write enables, and stalls in
// FETCH/MEMRD/MEMWR until the memory reports mem_ready.
//
// Optional feature macro: MULTI_CTRL_ADDI_EN (adds ADDIEX/ADDIWB and decodes
// Op=001000 as addi; when undefined that opcode is flagged illegal).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   Op[5:0]           opcode field IR[31:26]
//   Zero              ALU zero flag (qualifies PCWriteCond)
//   mem_ready         memory completes the current access this cycle
//   PCWrite .. RegDst datapath write enables / 1-bit mux selects
//   PCSource[1:0]     00 ALU result, 01 ALUOut, 10 jump target
//   ALUSrcB[1:0]      00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2
//   ALUop[1:0]        00 add, 01 sub, 10 funct decode
//   PCen              PCWrite | (PCWriteCond & Zero)
//   illegal_op        one-cycle flag in DECODE for an unsupported opcode
//   state[3:0]        current state encoding (debug)

module multi_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUop,
  output logic       PCen,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_e state_q, state_d;

  // Ungated control values; reset masking is applied at the outputs.
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, mem_to_reg;
  logic       ir_write, alu_src_a, reg_write, reg_dst, illegal;
  logic [1:0] pc_source, alu_src_b, alu_op;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    ir_write      = 1'b0;
    alu_src_a     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    illegal       = 1'b0;
    pc_source     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // IR load and PC+4 commit only on the cycle the read completes.
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (Op)
          OP_RTYPE:      state_d = S_EXEC;
          OP_LW, OP_SW:  state_d = S_MEMADR;
          OP_BEQ:        state_d = S_BEQ;
          OP_J:          state_d = S_JUMP;
`ifdef MULTI_CTRL_ADDI_EN
          OP_ADDI:       state_d = S_ADDIEX;
`else
          OP_ADDI: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
`endif
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        // Only lw/sw reach here; anything but sw is treated as a load.
        state_d   = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_RWB;
      end
      S_RWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        state_d   = S_FETCH;
      end
`ifdef MULTI_CTRL_ADDI_EN
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
`endif
      // Unused encodings (and the addi states when disabled) recover to FETCH.
      default: state_d = S_FETCH;
    endcase
  end

  // While rst is high every control is held low so no write can slip through.
  assign PCWrite     = pc_write      & ~rst;
  assign PCWriteCond = pc_write_cond & ~rst;
  assign IorD        = iord          & ~rst;
  assign MemRead     = mem_read      & ~rst;
  assign MemWrite    = mem_write     & ~rst;
  assign MemtoReg    = mem_to_reg    & ~rst;
  assign IRWrite     = ir_write      & ~rst;
  assign ALUSrcA     = alu_src_a     & ~rst;
  assign RegWrite    = reg_write     & ~rst;
  assign RegDst      = reg_dst       & ~rst;
  assign illegal_op  = illegal       & ~rst;
  assign PCSource    = pc_source     & {2{~rst}};
  assign ALUSrcB     = alu_src_b     & {2{~rst}};
  assign ALUop       = alu_op        & {2{~rst}};
  assign PCen        = (pc_write | (pc_write_cond & Zero)) & ~rst;
  assign state       = state_q;

endmodule

// File: tb/tb_multi_ctrl.sv
// tb/tb_multi_ctrl.sv - self-checking bench for multi_ctrl

module tb_multi_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] Op;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, ALUSrcA, RegWrite, RegDst, PCen, illegal_op;
  logic [1:0] PCSource, ALUSrcB, ALUop;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_ctrl dut (
    .clk(clk), .rst(rst), .Op(Op), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB), .ALUop(ALUop),
    .PCen(PCen), .illegal_op(illegal_op), .state(state)
  );

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

`ifdef MULTI_CTRL_ADDI_EN
  localparam bit ADDI_EN = 1'b1;
`else
  localparam bit ADDI_EN = 1'b0;
`endif

  typedef struct packed {
    logic       pcw, pcwc, iord, mr, mw, m2r, irw, asa, rw, rd;
    logic [1:0] pcs, asb, aop;
    logic       pcen, ill;
  } ctrl_t;

  // Expected state trace for one instruction plus the mem_ready value per cycle.
  int exp_st[$];
  bit exp_rdy[$];

  function automatic bit is_legal(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_J) || (ADDI_EN && op == OP_ADDI);
  endfunction

  // Control table written straight from the per-state description.
  function automatic ctrl_t exp_ctrl(input int st, input bit rdy, input bit z,
                                     input logic [5:0] op);
    ctrl_t c = '0;
    case (st)
      0:  begin c.mr = 1; c.asb = 2'b01; c.irw = rdy; c.pcw = rdy; end
      1:  begin c.asb = 2'b11; c.ill = !is_legal(op); end
      2:  begin c.asa = 1; c.asb = 2'b10; end
      3:  begin c.mr = 1; c.iord = 1; end
      4:  begin c.m2r = 1; c.rw = 1; end
      5:  begin c.mw = 1; c.iord = 1; end
      6:  begin c.asa = 1; c.aop = 2'b10; end
      7:  begin c.rd = 1; c.rw = 1; end
      8:  begin c.asa = 1; c.aop = 2'b01; c.pcwc = 1; c.pcs = 2'b01; end
      9:  begin c.pcw = 1; c.pcs = 2'b10; end
      10: begin c.asa = 1; c.asb = 2'b10; end
      11: begin c.rw = 1; end
      default: c = '0;
    endcase
    c.pcen = c.pcw | (c.pcwc & z);
    return c;
  endfunction

  function automatic ctrl_t actual();
    ctrl_t a;
    a.pcw = PCWrite; a.pcwc = PCWriteCond; a.iord = IorD; a.mr = MemRead;
    a.mw = MemWrite; a.m2r = MemtoReg; a.irw = IRWrite; a.asa = ALUSrcA;
    a.rw = RegWrite; a.rd = RegDst; a.pcs = PCSource; a.asb = ALUSrcB;
    a.aop = ALUop; a.pcen = PCen; a.ill = illegal_op;
    return a;
  endfunction

  task automatic add(input int s, input bit r);
    exp_st.push_back(s);
    exp_rdy.push_back(r);
  endtask

  // Build the expected trace from the opcode's step list and wait counts,
  // then drive it cycle by cycle and compare state and every control.
  task automatic run_instr(input string name, input logic [5:0] op, input bit z,
                           input int fw, input int mw);
    int irw_cnt = 0;
    ctrl_t e, a;
    exp_st.delete();
    exp_rdy.delete();
    for (int i = 0; i < fw; i++) add(0, 1'b0);
    add(0, 1'b1);
    add(1, 1'($urandom_range(0, 1)));
    if (!is_legal(op)) begin
    end else if (op == OP_R) begin
      add(6, 1'($urandom_range(0, 1))); add(7, 1'($urandom_range(0, 1)));
    end else if (op == OP_LW) begin
      add(2, 1'($urandom_range(0, 1)));
      for (int i = 0; i < mw; i++) add(3, 1'b0);
      add(3, 1'b1);
      add(4, 1'($urandom_range(0, 1)));
    end else if (op == OP_SW) begin
      add(2, 1'($urandom_range(0, 1)));
      for (int i = 0; i < mw; i++) add(5, 1'b0);
      add(5, 1'b1);
    end else if (op == OP_BEQ) begin
      add(8, 1'($urandom_range(0, 1)));
    end else if (op == OP_J) begin
      add(9, 1'($urandom_range(0, 1)));
    end else begin
      add(10, 1'($urandom_range(0, 1))); add(11, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < exp_st.size(); i++) begin
      @(negedge clk);
      rst = 1'b0;
      Zero = z;
      mem_ready = exp_rdy[i];
      // Op only needs to be valid where it is sampled.
      Op = (exp_st[i] == 1 || exp_st[i] == 2) ? op : 6'($urandom);
      #1;
      checks++;
      if (state !== 4'(exp_st[i])) begin
        errors++;
        $display("FAIL %s state cycle %0d: got %0d expected %0d", name, i, state, exp_st[i]);
      end
      e = exp_ctrl(exp_st[i], exp_rdy[i], z, op);
      a = actual();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s ctrl cycle %0d (state %0d): got %h expected %h",
                 name, i, exp_st[i], a, e);
      end
      if (IRWrite) irw_cnt++;
    end
    checks++;
    if (irw_cnt !== 1) begin
      errors++;
      $display("FAIL %s IRWrite pulses: got %0d expected 1", name, irw_cnt);
    end
  endtask

  task automatic test_reset();
    ctrl_t e;
    rst = 1'b1; mem_ready = 1'b0; Op = OP_R; Zero = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (state !== 4'd0 || actual() !== ctrl_t'(0)) begin
      errors++;
      $display("FAIL reset_initial: state %0d ctrl %h expected 0/0", state, actual());
    end
    // Walk a lw into its MEMRD wait.
    Op = OP_LW;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rst = 1'b0;
      mem_ready = (i < 3);
    end
    #1;
    checks++;
    if (state !== 4'd3 || MemRead !== 1'b1) begin
      errors++;
      $display("FAIL reset_setup: state %0d MemRead %b expected 3/1", state, MemRead);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rst = 1'b1; mem_ready = 1'b0;
      #1;
      checks++;
      if (actual() !== ctrl_t'(0) || state !== (i == 0 ? 4'd3 : 4'd0)) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: state %0d ctrl %h expected %0d/0",
                 i, state, actual(), (i == 0 ? 3 : 0));
      end
    end
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b0;
    #1;
    e = exp_ctrl(0, 1'b0, 1'b0, OP_LW);
    checks++;
    if (state !== 4'd0 || actual() !== e || MemRead !== 1'b1 || ALUSrcB !== 2'b01) begin
      errors++;
      $display("FAIL reset_release: state %0d ctrl %h expected 0/%h", state, actual(), e);
    end
  endtask

  task automatic test_latency();
    logic [5:0] ops[6] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    int         lat[6] = '{4, 5, 4, 3, 3, 4};
    for (int k = 0; k < 6; k++) begin
      int n = 0;
      bit back = 1'b0;
      if (ops[k] == OP_ADDI && !ADDI_EN) continue;
      while (n < 20) begin
        @(negedge clk);
        rst = 1'b0; mem_ready = 1'b1; Op = ops[k]; Zero = 1'b0;
        #1;
        if (n > 0 && state == 4'd0) begin
          back = 1'b1;
          break;
        end
        n++;
      end
      mem_ready = 1'b0;
      checks++;
      if (!back || n != lat[k]) begin
        errors++;
        $display("FAIL latency op %b: got %0d cycles (returned %b) expected %0d",
                 ops[k], n, back, lat[k]);
      end
    end
  endtask

  task automatic test_directed();
    run_instr("rtype", OP_R, 1'b0, 0, 0);
    run_instr("lw_waits", OP_LW, 1'b0, 2, 3);
    run_instr("sw_waits", OP_SW, 1'b1, 1, 2);
    run_instr("beq_z1", OP_BEQ, 1'b1, 0, 0);
    run_instr("beq_z0", OP_BEQ, 1'b0, 0, 0);
    run_instr("jump", OP_J, 1'b0, 0, 0);
    run_instr("illegal_3f", 6'b111111, 1'b0, 0, 0);
    run_instr("addi", OP_ADDI, 1'b0, 0, 0);
  endtask

  task automatic test_random();
    logic [5:0] legal[6] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    logic [5:0] op;
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 6) == 0) begin
        do op = 6'($urandom); while (is_legal(op));
      end else begin
        op = legal[$urandom_range(0, 5)];
      end
      run_instr("random", op, 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0) begin
      errors++;
      $display("FAIL random_end state: got %0d expected 0", state);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
